// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo functional units: op encodings, default
// tag width and the width of the CDB result record {tag, data[, ovf]}.
// Pure declarations; no logic, no latency, no flow control.
// Build option: ADDER_OVF_EN adds a 1-bit signed-overflow flag to the record.
package tomasulo_pkg;

  localparam logic OP_ADD    = 1'b0;
  localparam logic OP_SUB    = 1'b1;
  localparam int   TAG_W_DEF = 3;

`ifdef ADDER_OVF_EN
  localparam int OVF_W = 1;
`else
  localparam int OVF_W = 0;
`endif

  // Record is packed MSB..LSB as {tag, data[, ovf]}.
  function automatic int result_rec_w(input int width, input int tag_w);
    return tag_w + width + OVF_W;
  endfunction

endpackage

// File: rtl/adder_unit_pipe_if.sv
// Issue and CDB signal bundle between reservation station / arbiter and the adder unit.
// Latency: none (wires only).
// Backpressure: issue_ready throttles the station; cdb_gnt throttles result broadcast.
// Ports: master = station+arbiter side (drives issue_*, cdb_gnt); slave = adder unit side.
// Build option: ADDER_OVF_EN adds cdb_ovf.
import tomasulo_pkg::*;

interface adder_unit_pipe_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = TAG_W_DEF
);
  logic             issue_valid;
  logic             issue_ready;
  logic             issue_op;
  logic [WIDTH-1:0] issue_a;
  logic [WIDTH-1:0] issue_b;
  logic [TAG_W-1:0] issue_tag;
  logic             cdb_req;
  logic             cdb_gnt;
  logic [WIDTH-1:0] cdb_data;
  logic [TAG_W-1:0] cdb_tag;
`ifdef ADDER_OVF_EN
  logic             cdb_ovf;
`endif

  modport master (
    output issue_valid, issue_op, issue_a, issue_b, issue_tag, cdb_gnt,
    input  issue_ready, cdb_req, cdb_data, cdb_tag
`ifdef ADDER_OVF_EN
    , cdb_ovf
`endif
  );

  modport slave (
    input  issue_valid, issue_op, issue_a, issue_b, issue_tag, cdb_gnt,
    output issue_ready, cdb_req, cdb_data, cdb_tag
`ifdef ADDER_OVF_EN
    , cdb_ovf
`endif
  );
endinterface

// File: rtl/adder_unit_pipe_cdb_result_fifo.sv
// Synchronous result FIFO holding completed CDB records until granted.
// Latency: push visible at dout one edge later when empty; dout is the current head (no read latency).
// Backpressure: none internally; caller must not push when full unless popping the same cycle.
// Ports: Clock, Resetn (async active-low), push/din, pop/dout, full, empty, count.
module cdb_result_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 8
) (
  input  logic                       Clock,
  input  logic                       Resetn,
  input  logic                       push,
  input  logic [DATA_W-1:0]          din,
  input  logic                       pop,
  output logic [DATA_W-1:0]          dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              do_push;
  logic              do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_next(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  a_no_overflow: assert property (@(posedge Clock) disable iff (!Resetn) (push && full) |-> pop);

endmodule

// File: rtl/adder_unit_pipe.sv
// Pipelined integer add/sub unit: issue from the reservation station, broadcast {tag, result} on the CDB.
// Latency: issue fire at edge t -> result in output FIFO at edge t+LATENCY; one issue per cycle.
// Backpressure: credit counter caps ops in flight at OUTBUF_DEPTH; pipeline never stalls, FIFO waits for cdb_gnt.
// Ports: Clock, Resetn (async active-low), au (adder_unit_pipe_if.slave: issue_*, cdb_*), busy.
// Build option: ADDER_OVF_EN carries signed overflow to au.cdb_ovf.
module adder_unit_pipe
  import tomasulo_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int TAG_W        = TAG_W_DEF,
  parameter int LATENCY      = 2,
  parameter int OUTBUF_DEPTH = 2
) (
  input  logic              Clock,
  input  logic              Resetn,
  adder_unit_pipe_if.slave  au,
  output logic              busy
);

  localparam int CNT_W = $clog2(OUTBUF_DEPTH + 1);
  localparam int REC_W = result_rec_w(WIDTH, TAG_W);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] data;
`ifdef ADDER_OVF_EN
    logic             ovf;
`endif
  } res_t;

  logic [CNT_W-1:0]   inflight;
  logic               issue_fire;
  logic               cdb_fire;
  logic [WIDTH-1:0]   s1_sum;
  res_t               s1_rec;
  logic [LATENCY-1:0] p_vld;
  res_t               p_rec [LATENCY];
  res_t               head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;

  // Ready depends only on the credit register, so cdb_gnt never reaches issue_ready.
  assign au.issue_ready = (inflight < CNT_W'(OUTBUF_DEPTH));
  assign issue_fire     = au.issue_valid && au.issue_ready;
  assign cdb_fire       = au.cdb_req && au.cdb_gnt;
  assign busy           = (inflight != '0);

  // Stage-1 arithmetic, modulo 2^WIDTH.
  always_comb begin
    s1_sum = '0;
    unique case (au.issue_op)
      OP_ADD:  s1_sum = au.issue_a + au.issue_b;
      OP_SUB:  s1_sum = au.issue_a - au.issue_b;
      default: s1_sum = '0;
    endcase
  end

  always_comb begin
    s1_rec      = '0;
    s1_rec.tag  = au.issue_tag;
    s1_rec.data = s1_sum;
`ifdef ADDER_OVF_EN
    // Overflow when the effective operands share a sign that the result does not.
    // For SUB the effective B sign is inverted.
    s1_rec.ovf  = (au.issue_a[WIDTH-1] == (au.issue_b[WIDTH-1] ^ (au.issue_op == OP_SUB)))
               && (s1_sum[WIDTH-1] != au.issue_a[WIDTH-1]);
`endif
  end

  // Delay line: stage 0 captures the computed record, later stages only shift it.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      p_vld <= '0;
      for (int i = 0; i < LATENCY; i++) p_rec[i] <= '0;
    end else begin
      p_vld[0] <= issue_fire;
      if (issue_fire) p_rec[0] <= s1_rec;
      for (int i = 1; i < LATENCY; i++) begin
        p_vld[i] <= p_vld[i-1];
        p_rec[i] <= p_rec[i-1];
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      inflight <= '0;
    end else if (issue_fire && !cdb_fire) begin
      inflight <= inflight + 1'b1;
    end else if (!issue_fire && cdb_fire) begin
      inflight <= inflight - 1'b1;
    end
  end

  cdb_result_fifo #(
    .DEPTH  (OUTBUF_DEPTH),
    .DATA_W (REC_W)
  ) u_fifo (
    .Clock  (Clock),
    .Resetn (Resetn),
    .push   (p_vld[LATENCY-1]),
    .din    (p_rec[LATENCY-1]),
    .pop    (cdb_fire),
    .dout   (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign au.cdb_req  = !fifo_empty;
  assign au.cdb_data = head.data;
  assign au.cdb_tag  = head.tag;
`ifdef ADDER_OVF_EN
  assign au.cdb_ovf  = head.ovf;
`endif

  // Every buffered result still holds a credit, so a full FIFO implies no free credit.
  a_credit_covers_fifo: assert property (@(posedge Clock) disable iff (!Resetn) fifo_count <= inflight);
  a_full_blocks_issue:  assert property (@(posedge Clock) disable iff (!Resetn) fifo_full |-> !au.issue_ready);

endmodule
